pcs_link_ctrl: RTL



---
 rtl/pcs_link_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pcs_link_ctrl.sv
// Receive-side 1000BASE-X PCS link bring-up controller: comma-align control, sync qualification, link status.
// Optional loss-event statistics are built when PCS_LINK_STATS_EN is defined.
module pcs_link_ctrl #(
  parameter int unsigned LINK_TIMER     = 8,
  parameter int unsigned RESYNC_TIMEOUT = 16,
  parameter int unsigned RETRY_MAX      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       sync_status,
  input  logic       clear_cnt,
  output logic       align_en,
  output logic       realign,
  output logic       link_ok,
  output logic       link_fail,
  output logic [7:0] loss_count,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEARCH  = 3'd1,
    S_VERIFY  = 3'd2,
    S_LINK_UP = 3'd3,
    S_FAIL    = 3'd4
  } state_t;

  localparam logic [15:0] LINK_LAST   = 16'(LINK_TIMER - 1);
  localparam logic [15:0] RESYNC_LAST = 16'(RESYNC_TIMEOUT - 1);
  localparam logic [7:0]  RETRY_LAST  = 8'(RETRY_MAX - 1);

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  retries_q, retries_d;
  logic        align_en_q, realign_q, link_ok_q, link_fail_q;
  logic        realign_d;
  logic        loss_inc;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    retries_d = retries_q;
    realign_d = 1'b0;
    loss_inc  = 1'b0;
    if (!enable) begin
      state_d   = S_IDLE;
      timer_d   = '0;
      retries_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_SEARCH;
          timer_d   = '0;
          retries_d = '0;
        end
        S_SEARCH: begin
          // A coincident sync always beats the timeout.
          if (sync_status) begin
            state_d = S_VERIFY;
            timer_d = '0;
          end else if (timer_q == RESYNC_LAST) begin
            if (retries_q == RETRY_LAST) begin
              state_d = S_FAIL;
              timer_d = '0;
            end else begin
              retries_d = retries_q + 8'd1;
              timer_d   = '0;
              realign_d = 1'b1;
            end
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
        S_VERIFY: begin
          if (!sync_status) begin
            state_d = S_SEARCH;
            timer_d = '0;
          end else if (timer_q == LINK_LAST) begin
            state_d   = S_LINK_UP;
            retries_d = '0;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
        S_LINK_UP: begin
          if (!sync_status) begin
            state_d  = S_SEARCH;
            timer_d  = '0;
            loss_inc = 1'b1;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d   = S_IDLE;
          timer_d   = '0;
          retries_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they describe the state entered at this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      retries_q   <= '0;
      align_en_q  <= 1'b0;
      realign_q   <= 1'b0;
      link_ok_q   <= 1'b0;
      link_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retries_q   <= retries_d;
      align_en_q  <= (state_d == S_SEARCH);
      realign_q   <= realign_d;
      link_ok_q   <= (state_d == S_LINK_UP);
      link_fail_q <= (state_d == S_FAIL);
    end
  end

`ifdef PCS_LINK_STATS_EN
  logic [7:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if (clear_cnt) begin
      loss_d = '0;
    end else if (loss_inc && (loss_q != 8'hff)) begin
      loss_d = loss_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign loss_count = loss_q;
`else
  logic unused_stats;
  assign unused_stats = clear_cnt & loss_inc;
  assign loss_count   = 8'd0;
`endif

  assign align_en  = align_en_q;
  assign realign   = realign_q;
  assign link_ok   = link_ok_q;
  assign link_fail = link_fail_q;
  assign state_o   = state_q;

endmodule
